// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, functs, states,
// datapath selector codes and the decoded instruction-class bundle.
package ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned STATE_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FN_JR   = 6'h08;
    localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WBSEL_ALU = 2'b00;
    localparam logic [1:0] WBSEL_MEM = 2'b01;
    localparam logic [1:0] WBSEL_PC8 = 2'b11;

    localparam logic [1:0] PC_PC4 = 2'b00;
    localparam logic [1:0] PC_BEQ = 2'b01;
    localparam logic [1:0] PC_JAL = 2'b10;
    localparam logic [1:0] PC_RD1 = 2'b11;

    // One-hot instruction class; all-zero means the encoding is unsupported.
    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic j;
        logic jal;
    } instr_cls_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/funct to one-hot class plus illegal.
module mc_decode
    import ctrl_pkg::*;
(
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output instr_cls_t         cls,
    output logic               illegal
);

    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls.addu = 1'b1;
                    FN_SUBU: cls.subu = 1'b1;
                    FN_JR:   cls.jr   = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_J:    cls.j   = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: ;
        endcase
        illegal = (cls == '0);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// datapath selectors and write strobes; counts retired instructions.
module mc_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               isEqual,
    input  logic               mem_ready,
    output logic               PCWr,
    output logic               IRWr,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               ALUSrc,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         PC_SELECT,
    output logic [2:0]         ALUOp,
    output logic [1:0]         EXTOp,
    output logic [STATE_W-1:0] state,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    state_t     state_q;
    state_t     state_d;
    instr_cls_t cls;
    logic       dec_illegal;
    logic       retire_c;

    mc_decode u_decode (
        .op      (op),
        .funct   (funct),
        .cls     (cls),
        .illegal (dec_illegal)
    );

    assign state = state_q;

    // Next-state and per-state datapath controls.
    always_comb begin
        state_d   = ST_FETCH;
        PCWr      = 1'b0;
        IRWr      = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        ALUSrc    = 1'b0;
        RegDst    = DST_RT;
        MemtoReg  = WBSEL_ALU;
        PC_SELECT = PC_PC4;
        ALUOp     = ALU_ADD;
        EXTOp     = EXT_ZERO;
        illegal   = 1'b0;
        retire_c  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                IRWr    = 1'b1;
                PCWr    = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    illegal = 1'b1;
                end else if (cls.j || cls.jal) begin
                    PCWr      = 1'b1;
                    PC_SELECT = PC_JAL;
                    retire_c  = cls.j;
                    state_d   = cls.jal ? ST_WB : ST_FETCH;
                end else if (cls.jr) begin
                    PCWr      = 1'b1;
                    PC_SELECT = PC_RD1;
                    retire_c  = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls.addu || cls.subu) begin
                    ALUOp   = cls.subu ? ALU_SUB : ALU_ADD;
                    state_d = ST_WB;
                end else if (cls.ori) begin
                    ALUSrc  = 1'b1;
                    ALUOp   = ALU_OR;
                    state_d = ST_WB;
                end else if (cls.lui) begin
                    ALUSrc  = 1'b1;
                    EXTOp   = EXT_UPPER;
                    ALUOp   = ALU_LUI;
                    state_d = ST_WB;
                end else if (cls.lw || cls.sw) begin
                    ALUSrc  = 1'b1;
                    EXTOp   = EXT_SIGN;
                    state_d = ST_MEM;
                end else if (cls.beq) begin
                    ALUOp     = ALU_SUB;
                    EXTOp     = EXT_SIGN;
                    PC_SELECT = PC_BEQ;
                    PCWr      = isEqual;
                    retire_c  = 1'b1;
                end
            end
            ST_MEM: begin
                MemWrite = cls.sw;
                if (!(cls.lw || cls.sw)) begin
                    state_d = ST_FETCH;
                end else if (!mem_ready) begin
                    state_d = ST_MEM;
                end else if (cls.lw) begin
                    state_d = ST_WB;
                end else begin
                    retire_c = 1'b1;
                end
            end
            ST_WB: begin
                RegWrite = 1'b1;
                retire_c = 1'b1;
                if (cls.addu || cls.subu) begin
                    RegDst = DST_RD;
                end else if (cls.lw) begin
                    MemtoReg = WBSEL_MEM;
                end else if (cls.jal) begin
                    RegDst   = DST_RA;
                    MemtoReg = WBSEL_PC8;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        // A reset cycle must never commit architectural state.
        if (reset) begin
            PCWr     = 1'b0;
            IRWr     = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            illegal  = 1'b0;
            retire_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (retire_c) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected controls are queued per
// instruction and compared cycle by cycle against the DUT.
module tb_mc_ctrl;

    localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LW = 4, K_SW = 5;
    localparam int K_BEQ = 6, K_LUI = 7, K_J = 8, K_JAL = 9, K_ILL = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        isEqual;
    logic        mem_ready;
    logic        PCWr, IRWr, RegWrite, MemWrite, ALUSrc, illegal;
    logic [1:0]  RegDst, MemtoReg, PC_SELECT, EXTOp;
    logic [2:0]  ALUOp;
    logic [2:0]  state;
    logic [31:0] retired;

    typedef struct packed {
        logic [2:0]  st;
        logic [16:0] ctl;
        logic        mr;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int unsigned ret_cnt = 0;
    logic [16:0] ctl_obs;

    assign ctl_obs = {PCWr, IRWr, RegWrite, MemWrite, ALUSrc, RegDst, MemtoReg,
                      PC_SELECT, ALUOp, EXTOp, illegal};

    mc_ctrl #(.CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .isEqual   (isEqual),
        .mem_ready (mem_ready),
        .PCWr      (PCWr),
        .IRWr      (IRWr),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .ALUSrc    (ALUSrc),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .PC_SELECT (PC_SELECT),
        .ALUOp     (ALUOp),
        .EXTOp     (EXTOp),
        .state     (state),
        .illegal   (illegal),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // strb = {PCWr, IRWr, RegWrite, MemWrite}
    function automatic void push(input logic [2:0] st, input logic [3:0] strb,
                                 input logic alusrc, input logic [1:0] regdst,
                                 input logic [1:0] m2r, input logic [1:0] pcsel,
                                 input logic [2:0] aluop, input logic [1:0] ext,
                                 input logic ill, input logic mr);
        exp_t e;
        e.st  = st;
        e.ctl = {strb, alusrc, regdst, m2r, pcsel, aluop, ext, ill};
        e.mr  = mr;
        e.ret = ret_cnt;
        sb.push_back(e);
    endfunction

    // Entered just after a negedge in FETCH; leaves just after the negedge of the next cycle.
    task automatic run_instr(input string name, input int kind, input logic [5:0] o,
                             input logic [5:0] f, input logic eq, input int waits,
                             input int stop_after);
        exp_t e;
        int   n;
        op      = o;
        funct   = f;
        isEqual = eq;
        push(3'd0, 4'b1100, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1);
        case (kind)
            K_J, K_JAL: push(3'd1, 4'b1000, 1'b0, 2'b00, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0, 1'b1);
            K_JR:       push(3'd1, 4'b1000, 1'b0, 2'b00, 2'b00, 2'b11, 3'b000, 2'b00, 1'b0, 1'b1);
            K_ILL:      push(3'd1, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b1);
            default:    push(3'd1, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1);
        endcase
        case (kind)
            K_ADDU: begin
                push(3'd2, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1);
                push(3'd4, 4'b0010, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1);
            end
            K_SUBU: begin
                push(3'd2, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 3'b001, 2'b00, 1'b0, 1'b1);
                push(3'd4, 4'b0010, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1);
            end
            K_ORI: begin
                push(3'd2, 4'b0000, 1'b1, 2'b00, 2'b00, 2'b00, 3'b010, 2'b00, 1'b0, 1'b1);
                push(3'd4, 4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1);
            end
            K_LUI: begin
                push(3'd2, 4'b0000, 1'b1, 2'b00, 2'b00, 2'b00, 3'b011, 2'b10, 1'b0, 1'b1);
                push(3'd4, 4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1);
            end
            K_LW, K_SW: begin
                push(3'd2, 4'b0000, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b1);
                for (int i = 0; i <= waits; i++) begin
                    push(3'd3, (kind == K_SW) ? 4'b0001 : 4'b0000, 1'b0, 2'b00, 2'b00,
                         2'b00, 3'b000, 2'b00, 1'b0, (i == waits));
                end
                if (kind == K_LW)
                    push(3'd4, 4'b0010, 1'b0, 2'b00, 2'b01, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1);
            end
            K_BEQ:
                push(3'd2, {eq, 3'b000}, 1'b0, 2'b00, 2'b00, 2'b01, 3'b001, 2'b01, 1'b0, 1'b1);
            K_JAL:
                push(3'd4, 4'b0010, 1'b0, 2'b10, 2'b11, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1);
            default: ;
        endcase
        if (kind != K_ILL) ret_cnt++;
        n = 0;
        while (sb.size() > 0 && (stop_after == 0 || n < stop_after)) begin
            e = sb.pop_front();
            mem_ready = e.mr;
            #1;
            chk($sformatf("%s c%0d state", name, n), 32'(state), 32'(e.st));
            chk($sformatf("%s c%0d ctl", name, n), 32'(ctl_obs), 32'(e.ctl));
            chk($sformatf("%s c%0d retired", name, n), retired, e.ret);
            n++;
            @(negedge clk);
        end
        sb.delete();
    endtask

    initial begin
        reset     = 1'b1;
        op        = 6'h00;
        funct     = 6'h00;
        isEqual   = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset state", 32'(state), 32'd0);
        chk("reset retired", retired, 32'd0);
        chk("reset strobes", 32'({PCWr, IRWr, RegWrite, MemWrite, illegal}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_instr("addu", K_ADDU, 6'h00, 6'h21, 1'b0, 0, 0);
        run_instr("subu", K_SUBU, 6'h00, 6'h23, 1'b0, 0, 0);
        run_instr("ori",  K_ORI,  6'h0D, 6'h15, 1'b0, 0, 0);
        run_instr("lui",  K_LUI,  6'h0F, 6'h00, 1'b0, 0, 0);
        run_instr("lw2",  K_LW,   6'h23, 6'h04, 1'b0, 2, 0);
        run_instr("sw1",  K_SW,   6'h2B, 6'h08, 1'b0, 1, 0);
        run_instr("sw0",  K_SW,   6'h2B, 6'h00, 1'b0, 0, 0);
        run_instr("beq1", K_BEQ,  6'h04, 6'h02, 1'b1, 0, 0);
        run_instr("beq0", K_BEQ,  6'h04, 6'h02, 1'b0, 0, 0);
        run_instr("j",    K_J,    6'h02, 6'h10, 1'b0, 0, 0);
        run_instr("jal",  K_JAL,  6'h03, 6'h00, 1'b0, 0, 0);
        run_instr("jr",   K_JR,   6'h00, 6'h08, 1'b0, 0, 0);
        run_instr("ill3f", K_ILL, 6'h3F, 6'h00, 1'b0, 0, 0);
        run_instr("illfn", K_ILL, 6'h00, 6'h3F, 1'b0, 0, 0);
        run_instr("lw0",  K_LW,   6'h23, 6'h00, 1'b0, 0, 0);

        // Abort addu in WB with a 3-cycle reset.
        run_instr("addu_rst", K_ADDU, 6'h00, 6'h21, 1'b0, 0, 3);
        reset = 1'b1;
        #1;
        chk("rst wb state", 32'(state), 32'd4);
        chk("rst wb strobes", 32'({PCWr, IRWr, RegWrite, MemWrite, illegal}), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rst%0d state", i), 32'(state), 32'd0);
            chk($sformatf("rst%0d retired", i), retired, 32'd0);
            chk($sformatf("rst%0d strobes", i), 32'({PCWr, IRWr, RegWrite, MemWrite, illegal}), 32'd0);
        end
        @(negedge clk);
        reset   = 1'b0;
        ret_cnt = 0;
        run_instr("addu_post", K_ADDU, 6'h00, 6'h21, 1'b0, 0, 0);
        #1;
        chk("final retired", retired, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit that sequences the CPU datapath (PC, instruction register, register file, ALU, data memory) through FETCH/DECODE/EXEC/MEM/WB states. Each cycle it drives the existing selectors: ALU operand select, write-back data select, destination register select and next-PC select. It also drives the PC, IR, register-file and memory write strobes. It sits between the IR fields and the datapath, and replaces the single-cycle combinational controller.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  6  IR[31:26], from registered IR
- funct  in  6  IR[5:0]
- isEqual  in  1  comparator result, rs == rt
- mem_ready  in  1  data memory done; sampled only in MEM
- PCWr  out  1  PC write enable
- IRWr  out  1  IR write enable
- RegWrite  out  1  register-file write enable
- MemWrite  out  1  data-memory write enable
- ALUSrc  out  1  0 = RD2, 1 = EXTout
- RegDst  out  2  00 rt, 01 rd, 10 $31
- MemtoReg  out  2  00 ALU, 01 MemOut, 11 PC8
- PC_SELECT  out  2  00 PC4, 01 PC_BEQ (gated by isEqual), 10 PC_JAL, 11 RD1
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 lui
- EXTOp  out  2  00 zero, 01 sign, 10 upper
- state  out  3  current state, for debug
- illegal  out  1  one-cycle pulse on unsupported encoding
- retired  out  CNT_W  instructions completed

## Operation
- Supported instructions: addu (op 0, funct 0x21), subu (0x23), jr (0x08), ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, lui 0x0F, j 0x02, jal 0x03. Any other op, or op 0 with other funct, is illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5–7 are unreachable; if entered, the next state is FETCH.
- FETCH: IRWr=1, PCWr=1, PC_SELECT=00. Next state DECODE.
- DECODE:
  - j: PCWr=1, PC_SELECT=10, then FETCH.
  - jr: PCWr=1, PC_SELECT=11, then FETCH.
  - jal: PCWr=1, PC_SELECT=10, then WB.
  - illegal: illegal=1, then FETCH, with no strobes.
  - All others: next state EXEC.
- EXEC:
  - R-type: ALUSrc=0, ALUOp per funct, then WB.
  - ori: ALUSrc=1, EXTOp=00, ALUOp=010, then WB.
  - lui: ALUSrc=1, EXTOp=10, ALUOp=011, then WB.
  - lw/sw: ALUSrc=1, EXTOp=01, ALUOp=000, then MEM.
  - beq: ALUOp=001, EXTOp=01, PC_SELECT=01, PCWr=isEqual, then FETCH, retire.
- MEM: holds while mem_ready=0.
  - sw: MemWrite=1 for every MEM cycle; exit to FETCH and retire when mem_ready=1.
  - lw: exit to WB when mem_ready=1.
- WB: RegWrite=1, then FETCH, retire.
  - R-type: RegDst=01, MemtoReg=00.
  - ori/lui: RegDst=00, MemtoReg=00.
  - lw: RegDst=00, MemtoReg=01.
  - jal: RegDst=10, MemtoReg=11.
- Default outputs in every state are 0, except where listed above.
- Retire means retired increments on the cycle leaving the final state of a legal instruction. j/jr retire on leaving DECODE. Illegal instructions do not retire. The counter wraps from all-ones to 0.

## Timing
- Outputs are combinational from the state register plus op/funct. IR is stable from DECODE onward.
- Cycles per instruction, with mem_ready tied high:
  - j, jr: 2
  - beq, jal: 3
  - R-type, ori, lui, sw: 4
  - lw: 5
  - Each cycle mem_ready is held low adds 1 cycle to lw/sw.
- Reset behaviour:
  - During a reset-high cycle, all strobes and illegal are forced to 0.
  - On the next edge: state=FETCH, retired=0.
  - Reset asserted mid-instruction aborts it with no write.
- In the first cycle after reset deasserts, state is FETCH and IRWr=1.
- isEqual is sampled only in EXEC of beq. mem_ready is sampled only in MEM.

## Structure
- Package ctrl_pkg holds:
  - opcode and funct constants;
  - state encodings;
  - ALUOp, EXTOp, RegDst, MemtoReg and PC_SELECT encodings.
- Sub-module mc_decode is combinational. It maps op/funct to a one-hot instruction class plus illegal. mc_ctrl instantiates it once.
- The top level holds the state register, the next-state logic, the per-state output logic and the retired counter.

## Test plan
- Reset: hold reset 3 cycles during WB of addu → no RegWrite pulse; state=0 and retired=0 after release.
- addu $3,$1,$2 (op 0, funct 0x21) → states 0,1,2,4,0. WB shows RegDst=01, MemtoReg=00, RegWrite=1. retired goes 0→1.
- lw with mem_ready low for 2 MEM cycles → MEM held for 3 cycles, then WB with MemtoReg=01. Total 7 cycles.
- beq with isEqual=1 → PCWr=1 with PC_SELECT=01 in EXEC. Repeat with isEqual=0 → PCWr=0. Both take 3 cycles.
- jal → DECODE: PCWr=1, PC_SELECT=10. WB: RegDst=10, MemtoReg=11. jr → 2 cycles with PC_SELECT=11.
- op=0x3F → illegal=1 for one cycle in DECODE, no write strobes, return to FETCH, retired unchanged.
